// File: rtl/nfc_pkg.sv
// rtl/nfc_pkg.sv - shared NFC command layout, arbiter state encoding and filler builder
package nfc_pkg;

   localparam int NFC_CMD_W = 33;
   localparam int RW_B      = 32;
   localparam int FA_LSB    = 14;
   localparam int MA_LSB    = 7;
   localparam int LEN_W     = 7;

   typedef enum logic [1:0] {
      INIT = 2'd0,
      ARB  = 2'd1,
      RUN  = 2'd2
   } arb_state_t;

   // Harmless 1-byte flash->mem read that keeps the NFC fed when nobody is requesting.
   function automatic logic [NFC_CMD_W-1:0] mk_filler(input logic [17:0] fa, input logic [6:0] ma);
      logic [NFC_CMD_W-1:0] c;
      c                      = '0;
      c[RW_B]                = 1'b1;
      c[FA_LSB +: 18]        = fa;
      c[MA_LSB +: 7]         = ma;
      c[LEN_W-1:0]           = 7'd1;
      return c;
   endfunction

endpackage

// File: rtl/nfc_rr_pick.sv
// rtl/nfc_rr_pick.sv - rotate-priority-rotate round-robin picker, first set req at or after rr_ptr
module nfc_rr_pick #(
   parameter int NREQ = 4
) (
   input  logic [NREQ-1:0] req,
   input  logic [2:0]      rr_ptr,
   output logic [2:0]      winner,
   output logic            any
);

   logic [2*NREQ-1:0] dbl;
   logic [NREQ-1:0]   rot;
   int                idx;

   always_comb begin
      dbl    = {req, req} >> rr_ptr;
      rot    = dbl[NREQ-1:0];
      any    = |req;
      winner = '0;
      idx    = 0;
      // Descending scan so the lowest rotated position is the one left standing.
      for (int j = NREQ - 1; j >= 0; j--) begin
         if (rot[j]) begin
            idx = j + int'(rr_ptr);
            if (idx >= NREQ) idx = idx - NREQ;
            winner = 3'(idx);
         end
      end
   end

endmodule

// File: rtl/nfc_cmd_arbiter.sv
// rtl/nfc_cmd_arbiter.sv - round-robin NFC command arbiter with idle filler; optional watchdog via NFC_ARB_WDOG_EN
module nfc_cmd_arbiter
   import nfc_pkg::*;
#(
   parameter int          NREQ           = 4,
   parameter logic [6:0]  SCRATCH_M_ADDR = 7'h7F,
   parameter logic [17:0] SCRATCH_F_ADDR = 18'h0,
   parameter int          WDOG_CYCLES    = 65535
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic [NREQ-1:0]           req,
   input  logic [NFC_CMD_W*NREQ-1:0] cmd_in,
   output logic [NREQ-1:0]           gnt,
   output logic [NREQ-1:0]           ack,
   output logic [NFC_CMD_W-1:0]      nfc_cmd,
   input  logic                      nfc_done,
   output logic                      busy,
   output logic [2:0]                owner,
   output logic                      err
);

   localparam logic [NFC_CMD_W-1:0] FILLER = mk_filler(SCRATCH_F_ADDR, SCRATCH_M_ADDR);
   localparam logic [NREQ-1:0]      ONE    = NREQ'(1);

   if (NREQ < 2 || NREQ > 8 || WDOG_CYCLES < 1 || WDOG_CYCLES > 65535) begin : g_bad_param
      $error("nfc_cmd_arbiter: parameter out of range");
   end

   arb_state_t state_q, state_d;
   logic [2:0] rr_ptr_q, rr_ptr_d;
   logic [2:0] pick_winner;
   logic       pick_any;
   logic       wdog_ev;

   logic [NREQ-1:0]      gnt_d, ack_d;
   logic [NFC_CMD_W-1:0] cmd_d;
   logic                 busy_d, err_d;
   logic [2:0]           owner_d;

   nfc_rr_pick #(.NREQ(NREQ)) u_pick (
      .req    (req),
      .rr_ptr (rr_ptr_q),
      .winner (pick_winner),
      .any    (pick_any)
   );

`ifdef NFC_ARB_WDOG_EN
   logic [15:0] wdog_q;

   // ARB is the NFC capture cycle, so only INIT/RUN time is charged to the watchdog.
   assign wdog_ev = !nfc_done && (state_q != ARB) && (wdog_q == 16'(WDOG_CYCLES - 1));

   always_ff @(posedge clk) begin
      if (!rst_n || nfc_done || wdog_ev) wdog_q <= '0;
      else if (state_q != ARB)           wdog_q <= wdog_q + 16'd1;
   end
`else
   assign wdog_ev = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (!rst_n) state_q <= INIT;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      if (wdog_ev)       state_d = INIT;
      else if (nfc_done) state_d = ARB;
      else if (state_q == ARB) state_d = RUN;
   end

   always_comb begin
      gnt_d    = '0;
      ack_d    = '0;
      cmd_d    = nfc_cmd;
      busy_d   = busy;
      owner_d  = owner;
      rr_ptr_d = rr_ptr_q;
      err_d    = err;
      if (wdog_ev) begin
         err_d  = 1'b1;
         busy_d = 1'b0;
         if (busy) ack_d = ONE << owner;
      end else if (nfc_done) begin
         if (busy) ack_d = ONE << owner;
         if (pick_any) begin
            cmd_d    = cmd_in[int'(pick_winner)*NFC_CMD_W +: NFC_CMD_W];
            gnt_d    = ONE << pick_winner;
            owner_d  = pick_winner;
            busy_d   = 1'b1;
            rr_ptr_d = (int'(pick_winner) == NREQ - 1) ? 3'd0 : pick_winner + 3'd1;
         end else begin
            cmd_d  = FILLER;
            busy_d = 1'b0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         gnt      <= '0;
         ack      <= '0;
         nfc_cmd  <= FILLER;
         busy     <= 1'b0;
         owner    <= '0;
         rr_ptr_q <= '0;
         err      <= 1'b0;
      end else begin
         gnt      <= gnt_d;
         ack      <= ack_d;
         nfc_cmd  <= cmd_d;
         busy     <= busy_d;
         owner    <= owner_d;
         rr_ptr_q <= rr_ptr_d;
         err      <= err_d;
      end
   end

endmodule

// File: tb/tb_nfc_cmd_arbiter.sv
// tb/tb_nfc_cmd_arbiter.sv - directed self-checking bench for nfc_cmd_arbiter
module tb_nfc_cmd_arbiter;

   localparam int NREQ = 4;
   localparam logic [32:0] FILLER = 33'h1_0000_3F81;

   logic             clk;
   logic             rst_n;
   logic [NREQ-1:0]  req;
   logic [33*NREQ-1:0] cmd_in;
   logic [NREQ-1:0]  gnt;
   logic [NREQ-1:0]  ack;
   logic [32:0]      nfc_cmd;
   logic             nfc_done;
   logic             busy;
   logic [2:0]       owner;
   logic             err;

   int checks;
   int errors;

   logic [32:0] cmds [NREQ];

   nfc_cmd_arbiter #(
      .NREQ           (NREQ),
      .SCRATCH_M_ADDR (7'h7F),
      .SCRATCH_F_ADDR (18'h0),
      .WDOG_CYCLES    (100)
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .req      (req),
      .cmd_in   (cmd_in),
      .gnt      (gnt),
      .ack      (ack),
      .nfc_cmd  (nfc_cmd),
      .nfc_done (nfc_done),
      .busy     (busy),
      .owner    (owner),
      .err      (err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL timeout: simulation did not reach summary");
      $fatal(1, "timeout");
   end

   // Inputs change on negedge; outputs are sampled on the following negedge.
   task automatic pulse_done();
      nfc_done = 1'b1;
      @(negedge clk);
      nfc_done = 1'b0;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) @(negedge clk);
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      idle(2);
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      req = '0;
      nfc_done = 1'b0;
      do_reset();
      checks++; if (gnt !== 4'b0000)  begin errors++; $display("FAIL reset_gnt got %b want 0000", gnt); end
      checks++; if (ack !== 4'b0000)  begin errors++; $display("FAIL reset_ack got %b want 0000", ack); end
      checks++; if (busy !== 1'b0)    begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
      checks++; if (owner !== 3'd0)   begin errors++; $display("FAIL reset_owner got %0d want 0", owner); end
      checks++; if (err !== 1'b0)     begin errors++; $display("FAIL reset_err got %b want 0", err); end
      checks++; if (nfc_cmd !== FILLER) begin errors++; $display("FAIL reset_cmd got %h want %h", nfc_cmd, FILLER); end
   endtask

   task automatic test_init_filler();
      idle(3);
      pulse_done();
      checks++; if (ack !== 4'b0000)  begin errors++; $display("FAIL init_ack got %b want 0000", ack); end
      checks++; if (gnt !== 4'b0000)  begin errors++; $display("FAIL init_gnt got %b want 0000", gnt); end
      checks++; if (nfc_cmd !== FILLER) begin errors++; $display("FAIL init_cmd got %h want %h", nfc_cmd, FILLER); end
      checks++; if (busy !== 1'b0)    begin errors++; $display("FAIL init_busy got %b want 0", busy); end
   endtask

   task automatic test_single();
      idle(2);
      req = 4'b0001;
      pulse_done();
      checks++; if (gnt !== 4'b0001)  begin errors++; $display("FAIL single_gnt got %b want 0001", gnt); end
      checks++; if (nfc_cmd !== 33'h0_0004_0288) begin errors++; $display("FAIL single_cmd got %h want 000040288", nfc_cmd); end
      checks++; if (busy !== 1'b1)    begin errors++; $display("FAIL single_busy got %b want 1", busy); end
      checks++; if (owner !== 3'd0)   begin errors++; $display("FAIL single_owner got %0d want 0", owner); end
      req = '0;
      idle(3);
      checks++; if (gnt !== 4'b0000 || nfc_cmd !== 33'h0_0004_0288 || busy !== 1'b1)
         begin errors++; $display("FAIL single_hold gnt %b cmd %h busy %b want 0000 000040288 1", gnt, nfc_cmd, busy); end
      pulse_done();
      checks++; if (ack !== 4'b0001)  begin errors++; $display("FAIL single_ack got %b want 0001", ack); end
      checks++; if (busy !== 1'b0 || nfc_cmd !== FILLER)
         begin errors++; $display("FAIL single_after busy %b cmd %h want 0 %h", busy, nfc_cmd, FILLER); end
   endtask

   task automatic test_rotation();
      logic [3:0] exp_ack;
      do_reset();
      pulse_done();
      req = 4'b1111;
      exp_ack = 4'b0000;
      for (int k = 0; k < 8; k++) begin
         idle(2);
         pulse_done();
         checks++; if (gnt !== (4'b0001 << (k % 4)))
            begin errors++; $display("FAIL rot_gnt k=%0d got %b want %b", k, gnt, 4'b0001 << (k % 4)); end
         checks++; if (ack !== exp_ack)
            begin errors++; $display("FAIL rot_ack k=%0d got %b want %b", k, ack, exp_ack); end
         checks++; if (nfc_cmd !== cmds[k % 4])
            begin errors++; $display("FAIL rot_cmd k=%0d got %h want %h", k, nfc_cmd, cmds[k % 4]); end
         exp_ack = 4'b0001 << (k % 4);
      end
      req = '0;
      idle(2);
      pulse_done();
      checks++; if (ack !== 4'b1000) begin errors++; $display("FAIL rot_last_ack got %b want 1000", ack); end
   endtask

   task automatic test_same_cycle();
      // rr_ptr is 0 here; a lone grant to 2 moves it to 3.
      req = 4'b0100;
      idle(2);
      pulse_done();
      checks++; if (gnt !== 4'b0100) begin errors++; $display("FAIL sc_setup_gnt got %b want 0100", gnt); end
      req = '0;
      idle(2);
      pulse_done();
      checks++; if (ack !== 4'b0100 || busy !== 1'b0)
         begin errors++; $display("FAIL sc_setup_ack ack %b busy %b want 0100 0", ack, busy); end
      idle(2);
      req = 4'b0100;
      pulse_done();
      checks++; if (gnt !== 4'b0100 || owner !== 3'd2)
         begin errors++; $display("FAIL sc_gnt gnt %b owner %0d want 0100 2", gnt, owner); end
      checks++; if (ack !== 4'b0000) begin errors++; $display("FAIL sc_ack got %b want 0000", ack); end
      idle(2);
      pulse_done();
      checks++; if (gnt !== 4'b0100 || ack !== 4'b0100)
         begin errors++; $display("FAIL b2b gnt %b ack %b want 0100 0100", gnt, ack); end
   endtask

   task automatic test_reset_mid();
      req = '0;
      idle(1);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      checks++; if (busy !== 1'b0 || gnt !== 4'b0000 || ack !== 4'b0000 || owner !== 3'd0 || nfc_cmd !== FILLER)
         begin errors++; $display("FAIL midrst_outs busy %b gnt %b ack %b owner %0d cmd %h", busy, gnt, ack, owner, nfc_cmd); end
      idle(2);
      req = 4'b1111;
      pulse_done();
      checks++; if (ack !== 4'b0000) begin errors++; $display("FAIL midrst_noack got %b want 0000", ack); end
      checks++; if (gnt !== 4'b0001) begin errors++; $display("FAIL midrst_ptr gnt %b want 0001", gnt); end
      req = '0;
      idle(2);
      pulse_done();
   endtask

`ifdef NFC_ARB_WDOG_EN
   task automatic test_wdog();
      int waited;
      do_reset();
      pulse_done();
      req = 4'b0010;
      idle(1);
      pulse_done();
      req = '0;
      waited = 0;
      while (err !== 1'b1 && waited < 300) begin
         @(negedge clk);
         waited++;
      end
      checks++; if (err !== 1'b1) begin errors++; $display("FAIL wdog_err got %b want 1", err); end
      checks++; if (ack !== 4'b0010 || busy !== 1'b0)
         begin errors++; $display("FAIL wdog_ack ack %b busy %b want 0010 0", ack, busy); end
      checks++; if (waited < 90 || waited > 110)
         begin errors++; $display("FAIL wdog_time waited %0d want about 100", waited); end
   endtask
`endif

   initial begin
      checks   = 0;
      errors   = 0;
      rst_n    = 1'b0;
      req      = '0;
      nfc_done = 1'b0;
      cmds[0]  = 33'h0_0004_0288;
      cmds[1]  = 33'h1_2345_6701;
      cmds[2]  = 33'h0_ABCD_E07F;
      cmds[3]  = 33'h1_FFFF_FF80;
      cmd_in   = {cmds[3], cmds[2], cmds[1], cmds[0]};
      @(negedge clk);
      test_reset();
      test_init_filler();
      test_single();
      test_rotation();
      test_same_cycle();
      test_reset_mid();
`ifdef NFC_ARB_WDOG_EN
      test_wdog();
`endif
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
